// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I data-side memory responder.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    localparam logic [3:0] REGION_RAM  = 4'h0;
    localparam logic [3:0] REGION_MMIO = 4'h1;

    // Byte offsets inside the MMIO region (word aligned)
    localparam logic [27:0] MMIO_GPIO   = 28'h000_0000;
    localparam logic [27:0] MMIO_TIMER  = 28'h000_0004;
    localparam logic [27:0] MMIO_STATUS = 28'h000_0008;

endpackage

// File: rtl/rv32i_data_mem_if.sv
// Core-to-data-memory load/store port: core drives the request, memory returns load data.
interface rv32i_data_mem_if;
    logic [2:0]  iFunct3;
    logic        iData_WrEn;
    logic [31:0] iData_Addr;
    logic [31:0] iData_WrData;
    logic [31:0] oData_RdData;

    modport master (
        output iFunct3, iData_WrEn, iData_Addr, iData_WrData,
        input  oData_RdData
    );

    modport slave (
        input  iFunct3, iData_WrEn, iData_Addr, iData_WrData,
        output oData_RdData
    );
endinterface

// File: rtl/rv32i_dmem_lane.sv
// Byte-lane steering: byte enables, store replication, load extraction/extension and
// the misalignment decision for one access.
module rv32i_dmem_lane
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLow,
    input  logic [31:0] wrData,
    input  logic [31:0] rdWord,
    output logic [3:0]  byteEn_c,
    output logic [31:0] wrWord_c,
    output logic [31:0] rdData_c,
    output logic        misalign_c,
    output logic        legal_c
);
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    funct3_e     op;

    assign op     = funct3_e'(funct3);
    assign rdByte = rdWord[{addrLow, 3'b000} +: 8];
    assign rdHalf = addrLow[1] ? rdWord[31:16] : rdWord[15:0];

    // Misaligned or illegal accesses leave byte enables and read data at zero
    always_comb begin
        byteEn_c   = 4'b0000;
        wrWord_c   = wrData;
        rdData_c   = 32'h0;
        misalign_c = 1'b0;
        legal_c    = 1'b1;
        case (op)
            F3_B, F3_BU: begin
                byteEn_c = 4'(4'b0001 << addrLow);
                wrWord_c = {4{wrData[7:0]}};
                rdData_c = (op == F3_B) ? {{24{rdByte[7]}}, rdByte} : {24'h0, rdByte};
            end
            F3_H, F3_HU: begin
                wrWord_c = {2{wrData[15:0]}};
                if (addrLow[0]) begin
                    misalign_c = 1'b1;
                end else begin
                    byteEn_c = addrLow[1] ? 4'b1100 : 4'b0011;
                    rdData_c = (op == F3_H) ? {{16{rdHalf[15]}}, rdHalf} : {16'h0, rdHalf};
                end
            end
            F3_W: begin
                if (addrLow != 2'b00) begin
                    misalign_c = 1'b1;
                end else begin
                    byteEn_c = 4'b1111;
                    rdData_c = rdWord;
                end
            end
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_data_mem.sv
// Data memory for the single-cycle RV32I core: word RAM plus GPIO/STATUS MMIO window.
// Define DMEM_TIMER_EN to build the free-running TIMER register at MMIO offset 0x4.
module rv32i_data_mem
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
)(
    input  logic             iClk,
    input  logic             iRst,
    rv32i_data_mem_if.slave  bus,
    output logic [31:0]      oGpio,
    output logic             oMisalign
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           ram [DEPTH];
    logic [ADDR_WIDTH-1:0] ramIdx;
    logic [27:0]           mmioOff;
    logic                  isRam;
    logic                  isMmio;
    logic [3:0]            byteEn;
    logic [31:0]           wrWord;
    logic [31:0]           rdWord;
    logic [31:0]           timerVal;
    logic                  misalign;
    logic                  legal;
    logic                  wrOk;
    logic                  gpioWr;
    logic                  statusClr;

    assign isRam   = (bus.iData_Addr[31:28] == REGION_RAM);
    assign isMmio  = (bus.iData_Addr[31:28] == REGION_MMIO);
    assign ramIdx  = bus.iData_Addr[ADDR_WIDTH+1:2];
    assign mmioOff = {bus.iData_Addr[27:2], 2'b00};

    rv32i_dmem_lane u_lane (
        .funct3     (bus.iFunct3),
        .addrLow    (bus.iData_Addr[1:0]),
        .wrData     (bus.iData_WrData),
        .rdWord     (rdWord),
        .byteEn_c   (byteEn),
        .wrWord_c   (wrWord),
        .rdData_c   (bus.oData_RdData),
        .misalign_c (misalign),
        .legal_c    (legal)
    );

    assign wrOk      = bus.iData_WrEn && legal && !misalign;
    assign gpioWr    = wrOk && isMmio && (mmioOff == MMIO_GPIO);
    assign statusClr = wrOk && isMmio && (mmioOff == MMIO_STATUS) && byteEn[0] && wrWord[0];

    // Source word for the load path before lane extraction
    always_comb begin
        rdWord = 32'h0;
        if (isRam) begin
            rdWord = ram[ramIdx];
        end else if (isMmio) begin
            case (mmioOff)
                MMIO_GPIO:   rdWord = oGpio;
                MMIO_TIMER:  rdWord = timerVal;
                MMIO_STATUS: rdWord = {31'h0, oMisalign};
                default:     rdWord = 32'h0;
            endcase
        end
    end

    // RAM has no reset; stores are dropped while reset is held
    always_ff @(posedge iClk) begin
        if (!iRst && wrOk && isRam) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    ram[ramIdx][8*i +: 8] <= wrWord[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oGpio <= 32'h0;
        end else if (gpioWr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    oGpio[8*i +: 8] <= wrWord[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oMisalign <= 1'b0;
        end else if (misalign) begin
            oMisalign <= 1'b1;
        end else if (statusClr) begin
            oMisalign <= 1'b0;
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] timer;
    logic        timerWr;

    // Only full-word stores load the counter; a load beats the increment
    assign timerWr = wrOk && isMmio && (mmioOff == MMIO_TIMER)
                     && (funct3_e'(bus.iFunct3) == F3_W);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            timer <= 32'h0;
        end else if (timerWr) begin
            timer <= wrWord;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    assign timerVal = timer;
`else
    assign timerVal = 32'h0;
`endif

endmodule

// File: tb/tb_rv32i_data_mem.sv
// Self-checking bench for rv32i_data_mem: directed vector table, corner sequences and
// randomized accesses against a byte-level reference model.
module tb_rv32i_data_mem;
    import rv32i_pkg::*;

    logic iClk;
    logic iRst;
    logic [31:0] oGpio;
    logic        oMisalign;

    rv32i_data_mem_if bus ();

    rv32i_data_mem #(.ADDR_WIDTH(8)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .bus       (bus),
        .oGpio     (oGpio),
        .oMisalign (oMisalign)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int unsigned nCompared = 0;
    int unsigned nMismatch = 0;

    // Reference model state
    logic [7:0]  mem [1024];
    logic [31:0] mGpio;
    logic        mStatus;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expMis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        bus.iData_WrEn   = we;
        bus.iFunct3      = f3;
        bus.iData_Addr   = a;
        bus.iData_WrData = d;
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    function automatic int accSize(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic isMis(input logic [31:0] a, input logic [2:0] f3);
        int s = accSize(f3);
        return (s > 1) && ((a % s) != 0);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input logic [2:0] f3);
        int s = accSize(f3);
        logic [31:0] w = 32'h0;
        logic [31:0] v;
        int base;
        if (s == 0 || isMis(a, f3)) return 32'h0;
        if (a[31:28] == 4'h0) begin
            base = int'(a & 32'h3FC);
            w = {mem[base+3], mem[base+2], mem[base+1], mem[base]};
        end else if (a[31:28] == 4'h1) begin
            case (a[27:0] & 28'hFFF_FFFC)
                28'h0:   w = mGpio;
                28'h8:   w = {31'h0, mStatus};
                default: w = 32'h0;
            endcase
        end
        v = w >> (8 * (a % 4));
        if (s == 1) v = v & 32'hFF;
        else if (s == 2) v = v & 32'hFFFF;
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic modelUpdate(input logic we, input logic [31:0] a, input logic [2:0] f3,
                               input logic [31:0] d);
        int s = accSize(f3);
        logic [7:0] b;
        if (isMis(a, f3)) begin
            mStatus = 1'b1;
        end else if (we && s != 0) begin
            for (int k = 0; k < s; k++) begin
                b = d[8*k +: 8];
                if (a[31:28] == 4'h0) begin
                    mem[int'(a & 32'h3FF) + k] = b;
                end else if (a[31:28] == 4'h1) begin
                    if ((a[27:0] & 28'hFFF_FFFC) == 28'h0)
                        mGpio[8*(int'(a % 4) + k) +: 8] = b;
                    else if ((a[27:0] & 28'hFFF_FFFC) == 28'h8 && (a % 4) == 0 && k == 0 && b[0])
                        mStatus = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] r = $urandom();
        int sel = $urandom_range(0, 9);
        logic [31:0] offs;
        logic [3:0] top;
        if (sel < 6) return {4'h0, r[27:0]};
        if (sel < 9) begin
            case ($urandom_range(0, 3))
                0:       offs = 32'h0;
                1:       offs = 32'h8;
                2:       offs = 32'hC;
                default: offs = 32'h40;
            endcase
            return 32'h1000_0000 + offs + {30'h0, r[1:0]};
        end
        top = 4'(2 + $urandom_range(0, 13));
        return {top, r[27:0]};
    endfunction

    initial begin
        logic [31:0] a, d, e;
        logic [2:0]  f3;
        logic        we;

        mGpio   = 32'h0;
        mStatus = 1'b0;
        iRst    = 1'b1;
        drive(1'b0, F3_W, 32'h0, 32'h0);

        // Reset state
        #12;
        check("reset gpio", oGpio, 32'h0);
        check("reset misalign", {31'h0, oMisalign}, 32'h0);
        drive(1'b0, F3_W, 32'h1000_0004, 32'h0);
        #1;
        check("reset timer read", bus.oData_RdData, 32'h0);
        drive(1'b0, F3_W, 32'h0, 32'h0);
        @(negedge iClk);
        iRst = 1'b0;
        step();

        // GPIO byte store
        drive(1'b1, F3_B, 32'h1000_0001, 32'h0000_003C);
        step();
        drive(1'b0, F3_W, 32'h0, 32'h0);
        mGpio = 32'h0000_3C00;
        check("gpio sb", oGpio, 32'h0000_3C00);

        // Directed vector table
        vecs.push_back('{1'b1, F3_W,   32'h0000_0010, 32'h8081_82F3, 32'h0,          1'b0});
        vecs.push_back('{1'b0, F3_B,   32'h0000_0010, 32'h0,         32'hFFFF_FFF3, 1'b0});
        vecs.push_back('{1'b0, F3_BU,  32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, F3_H,   32'h0000_0012, 32'h0,         32'hFFFF_8081, 1'b0});
        vecs.push_back('{1'b0, F3_HU,  32'h0000_0010, 32'h0,         32'h0000_82F3, 1'b0});
        vecs.push_back('{1'b0, F3_B,   32'h0000_0012, 32'h0,         32'hFFFF_FF81, 1'b0});
        vecs.push_back('{1'b1, F3_W,   32'h0000_0020, 32'h0,         32'h0,          1'b0});
        vecs.push_back('{1'b1, F3_B,   32'h0000_0021, 32'h0000_00AB, 32'h0,          1'b0});
        vecs.push_back('{1'b1, F3_H,   32'h0000_0022, 32'h0000_1234, 32'h0,          1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h0000_0020, 32'h0,         32'h1234_AB00, 1'b0});
        vecs.push_back('{1'b1, F3_W,   32'h0000_0004, 32'h0,         32'h0,          1'b0});
        vecs.push_back('{1'b1, F3_W,   32'h0000_0006, 32'hDEAD_BEEF, 32'h0,          1'b1});
        vecs.push_back('{1'b0, F3_W,   32'h0000_0004, 32'h0,         32'h0,          1'b1});
        vecs.push_back('{1'b1, F3_W,   32'h1000_0008, 32'h0000_0001, 32'h0,          1'b0});
        vecs.push_back('{1'b1, F3_W,   32'h0000_0400, 32'h0000_005A, 32'h0,          1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h0000_0000, 32'h0,         32'h0000_005A, 1'b0});
        vecs.push_back('{1'b0, F3_HU,  32'h0000_0011, 32'h0,         32'h0,          1'b1});
        vecs.push_back('{1'b0, F3_W,   32'h1000_0008, 32'h0,         32'h0000_0001, 1'b1});
        vecs.push_back('{1'b1, 3'b011, 32'h1000_0008, 32'h0000_0001, 32'h0,          1'b1});
        vecs.push_back('{1'b0, 3'b110, 32'h0000_0010, 32'h0,         32'h0,          1'b1});
        vecs.push_back('{1'b1, F3_B,   32'h1000_0008, 32'h0000_0001, 32'h0,          1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h1000_0008, 32'h0,         32'h0,          1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h2000_0010, 32'h0,         32'h0,          1'b0});
        vecs.push_back('{1'b1, F3_W,   32'h3000_0020, 32'hFFFF_FFFF, 32'h0,          1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h0000_0020, 32'h0,         32'h1234_AB00, 1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h1000_0000, 32'h0,         32'h0000_3C00, 1'b0});
        vecs.push_back('{1'b0, F3_BU,  32'h1000_0001, 32'h0,         32'h0000_003C, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            #1;
            if (!vecs[i].we)
                check($sformatf("vec[%0d] rd", i), bus.oData_RdData, vecs[i].expRd);
            step();
            check($sformatf("vec[%0d] misalign", i), {31'h0, oMisalign}, {31'h0, vecs[i].expMis});
        end

        // TIMER load, wrap and SB-ignore
        drive(1'b1, F3_W, 32'h1000_0004, 32'hFFFF_FFFE);
        step();
        drive(1'b0, F3_W, 32'h1000_0004, 32'h0);
        #1;
`ifdef DMEM_TIMER_EN
        check("timer load", bus.oData_RdData, 32'hFFFF_FFFE);
        step();
        check("timer +1", bus.oData_RdData, 32'hFFFF_FFFF);
        step();
        check("timer wrap", bus.oData_RdData, 32'h0);
        drive(1'b1, F3_B, 32'h1000_0004, 32'h0000_0055);
        step();
        drive(1'b0, F3_W, 32'h1000_0004, 32'h0);
        #1;
        check("timer sb ignored", bus.oData_RdData, 32'h0000_0001);
`else
        check("timer absent", bus.oData_RdData, 32'h0);
        step();
        check("timer absent later", bus.oData_RdData, 32'h0);
`endif

        // Fill RAM (through aliases) so every random load has a known answer
        for (int i = 0; i < 256; i++) begin
            a = 32'(i * 4) + (32'($urandom_range(0, 3)) << 10);
            d = $urandom();
            drive(1'b1, F3_W, a, d);
            modelUpdate(1'b1, a, F3_W, d);
            step();
        end

        // Randomized accesses against the model
        for (int n = 0; n < 500; n++) begin
            a  = randAddr();
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            d  = $urandom();
            drive(we, f3, a, d);
            #1;
            e = modelRead(a, f3);
            check($sformatf("rand[%0d] rd a=%08h f3=%0d", n, a, f3), bus.oData_RdData, e);
            modelUpdate(we, a, f3, d);
            step();
            check($sformatf("rand[%0d] gpio", n), oGpio, mGpio);
            check($sformatf("rand[%0d] misalign", n), {31'h0, oMisalign}, {31'h0, mStatus});
        end

        // Asynchronous reset between edges
        drive(1'b1, F3_W, 32'h1000_0000, 32'hA5A5_0001);
        step();
        mGpio = 32'hA5A5_0001;
        drive(1'b0, F3_W, 32'h0000_0002, 32'h0);
        step();
        mStatus = 1'b1;
        check("pre-reset gpio", oGpio, mGpio);
        check("pre-reset misalign", {31'h0, oMisalign}, 32'h1);
        drive(1'b0, F3_W, 32'h0000_0030, 32'h0);
        #2;
        iRst = 1'b1;
        #1;
        check("async rst gpio", oGpio, 32'h0);
        check("async rst misalign", {31'h0, oMisalign}, 32'h0);
        check("ram read in reset", bus.oData_RdData, modelRead(32'h30, F3_W));
        drive(1'b0, F3_W, 32'h1000_0004, 32'h0);
        #1;
        check("async rst timer", bus.oData_RdData, 32'h0);
        drive(1'b1, F3_W, 32'h0000_0030, 32'h0000_0077);
        step();
        drive(1'b0, F3_W, 32'h0, 32'h0);
        mGpio   = 32'h0;
        mStatus = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
        step();
        drive(1'b0, F3_W, 32'h0000_0030, 32'h0);
        #1;
        check("store dropped in reset", bus.oData_RdData, modelRead(32'h30, F3_W));
        check("post-reset gpio", oGpio, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
